// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter sharing one Occ ROM read port between N_REQ cores.
// One read in flight at a time; a missing ROM response times out with zero data and a sticky error.
module occ_rom_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_ce_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [DATA_W-1:0]         req_data_o,
    output logic [N_REQ-1:0]          req_valid_o,
    output logic                      ce_rom_Occ_o,
    output logic [ADDR_W-1:0]         addr_rom_Occ_o,
    input  logic [DATA_W-1:0]         data_Occ_i,
    input  logic                      data_Occ_valid_i,
    output logic                      err_o,
    input  logic                      err_clr_i,
    output logic                      busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rr_ptr, grant_idx;
    logic [IDX_W-1:0]   pick, pick_hi, pick_lo;
    logic               found, found_hi, found_lo;
    logic [ADDR_W-1:0]  addr_reg, pick_addr;
    logic [DATA_W-1:0]  data_reg;
    logic [7:0]         cnt;
    logic               err, guard;
    logic               timeout_hit;
    logic [N_REQ-1:0]   grant_oh, req_masked;

    assign grant_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
    // The core just served is hidden for one IDLE cycle so it can drop ce without being re-granted.
    assign req_masked = req_ce_i & ~(guard ? grant_oh : '0);

    // First requester at or above the pointer wins; otherwise wrap to the lowest one below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_masked[j]) begin
                if (IDX_W'(j) >= rr_ptr) begin
                    found_hi = 1'b1;
                    pick_hi  = IDX_W'(j);
                end else begin
                    found_lo = 1'b1;
                    pick_lo  = IDX_W'(j);
                end
            end
        end
        pick  = found_hi ? pick_hi : pick_lo;
        found = found_hi | found_lo;
    end

    always_comb begin
        pick_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                pick_addr = req_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign timeout_hit = (state == WAIT) && !data_Occ_valid_i && ((cnt + 8'd1) == TIMEOUT_C);

    always_comb begin
        state_nx       = state;
        ce_rom_Occ_o   = 1'b0;
        req_valid_o    = '0;
        addr_rom_Occ_o = addr_reg;
        req_data_o     = data_reg;
        err_o          = err;
        busy_o         = (state != IDLE);
        case (state)
            IDLE:  if (found) state_nx = ISSUE;
            ISSUE: begin
                ce_rom_Occ_o = 1'b1;
                state_nx     = WAIT;
            end
            WAIT:  if (data_Occ_valid_i || timeout_hit) state_nx = RESP;
            RESP: begin
                req_valid_o = grant_oh;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            guard     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    guard <= 1'b0;
                    if (found) begin
                        grant_idx <= pick;
                        addr_reg  <= pick_addr;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (data_Occ_valid_i) begin
                        data_reg <= data_Occ_i;
                    end else if (timeout_hit) begin
                        data_reg <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                    guard  <= 1'b1;
                end
                default: ;
            endcase
            // A timeout in the same cycle as a clear request keeps the flag set.
            if (timeout_hit) begin
                err <= 1'b1;
            end else if (err_clr_i) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Scoreboard bench for occ_rom_arbiter: core agents push expected responses, a monitor pops and checks them.
// The ROM model answers with a data word derived from the address after a configurable latency.
module tb_occ_rom_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_ce = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [DW-1:0]   req_data;
    logic [N-1:0]    req_valid;
    logic            ce_rom;
    logic [AW-1:0]   addr_rom;
    logic [DW-1:0]   rom_data = '0;
    logic            rom_valid = 1'b0;
    logic            err;
    logic            err_clr = 1'b0;
    logic            busy;

    always #5 clk = ~clk;

    occ_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_ce_i         (req_ce),
        .req_addr_i       (req_addr),
        .req_data_o       (req_data),
        .req_valid_o      (req_valid),
        .ce_rom_Occ_o     (ce_rom),
        .addr_rom_Occ_o   (addr_rom),
        .data_Occ_i       (rom_data),
        .data_Occ_valid_i (rom_valid),
        .err_o            (err),
        .err_clr_i        (err_clr),
        .busy_o           (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int issued   = 0;
    int served   = 0;

    logic [7:0]  cmd_q[N][$];
    logic [32:0] exp_q[N][$];
    int          exp_order[$];
    int          lat_q[$];
    logic        active[N]     = '{default: 1'b0};
    int          linger[N]     = '{default: 0};
    logic        hold_extra[N] = '{default: 1'b0};
    logic        rom_silent    = 1'b0;
    int          rom_lat_min   = 1;
    int          rom_lat_max   = 1;

    function automatic logic [31:0] rom_fn(input logic [7:0] a);
        return {16'hA5A5, 8'h00, a};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core agents: hold ce until their valid strobe, optionally lingering over the guard cycle.
    always @(negedge clk) begin : agents
        logic [7:0] a;
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                active[k] = 1'b0;
                linger[k] = 0;
                req_ce[k] = 1'b0;
                cmd_q[k].delete();
                exp_q[k].delete();
            end else if (active[k]) begin
                if (linger[k] > 0) begin
                    linger[k]--;
                    if (linger[k] == 0) begin
                        req_ce[k] = 1'b0;
                        active[k] = 1'b0;
                    end
                end else if (req_valid[k]) begin
                    if (hold_extra[k]) begin
                        linger[k] = 2;
                    end else begin
                        req_ce[k] = 1'b0;
                        active[k] = 1'b0;
                    end
                end
            end else if (cmd_q[k].size() > 0) begin
                a = cmd_q[k].pop_front();
                req_addr[k*AW +: AW] = a;
                req_ce[k] = 1'b1;
                active[k] = 1'b1;
                exp_q[k].push_back(rom_silent ? {1'b1, 32'h0} : {1'b0, rom_fn(a)});
                issued++;
            end
        end
    end

    // ROM model: sees the ce cycle, answers after the chosen latency, junk data otherwise.
    int         rom_cnt = 0;
    logic [7:0] rom_addr = '0;
    always @(negedge clk) begin
        rom_valid = 1'b0;
        rom_data  = $urandom;
        if (!rst_n) lat_q.delete();
        if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0) begin
                rom_valid = 1'b1;
                rom_data  = rom_fn(rom_addr);
            end
        end
        if (ce_rom === 1'b1) begin
            rom_addr = addr_rom;
            if (rom_silent) begin
                lat_q.push_back(TO + 1);
            end else begin
                rom_cnt = int'($urandom_range(rom_lat_max, rom_lat_min));
                lat_q.push_back(rom_cnt + 1);
            end
        end
    end

    // Monitor: pops the expectation of whichever core gets a valid strobe.
    int   cyc = 0;
    int   ce_cyc = 0;
    logic ce_prev = 1'b0;
    always @(posedge clk) begin : monitor
        logic [32:0] e;
        int o;
        int l;
        #1;
        cyc++;
        if (ce_rom === 1'b1) begin
            checkOutput("ce_not_back_to_back", ce_prev, 0);
            ce_cyc = cyc;
        end
        ce_prev = (ce_rom === 1'b1);
        if (req_valid !== '0) begin
            checkOutput("valid_onehot", $onehot(req_valid), 1);
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] === 1'b1) begin
                    served++;
                    if (exp_q[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_valid: got strobe for core %0d expected none", k);
                    end else begin
                        e = exp_q[k].pop_front();
                        checkOutput("resp_data", req_data, e[31:0]);
                        if (e[32]) checkOutput("timeout_err", err, 1);
                    end
                    if (exp_order.size() > 0) begin
                        o = exp_order.pop_front();
                        checkOutput("grant_order", k, o);
                    end
                    if (lat_q.size() > 0) begin
                        l = lat_q.pop_front();
                        checkOutput("ce_to_valid_latency", cyc - ce_cyc, l);
                    end else begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL latency: got strobe with no ROM read outstanding expected none");
                    end
                end
            end
        end
    end

    function automatic bit allIdle();
        for (int k = 0; k < N; k++) begin
            if (cmd_q[k].size() != 0 || active[k] || exp_q[k].size() != 0) return 1'b0;
        end
        return (busy === 1'b0) && (lat_q.size() == 0);
    endfunction

    task automatic syncTb();
        @(negedge clk);
        #1;
    endtask

    task automatic waitDrained(input string tag, input int budget);
        int n = 0;
        syncTb();
        while (!allIdle() && n < budget) begin
            syncTb();
            n++;
        end
        checkOutput({tag, "_drained"}, allIdle(), 1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ce"}, ce_rom, 0);
        checkOutput({tag, "_valid"}, req_valid, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_data"}, req_data, 0);
        checkOutput({tag, "_addr"}, addr_rom, 0);
    endtask

    task automatic resetDut();
        syncTb();
        rst_n = 1'b0;
        syncTb();
        syncTb();
        rst_n = 1'b1;
        exp_order.delete();
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] a);
        cmd_q[k].push_back(a);
    endtask

    initial begin
        int n;
        repeat (3) syncTb();
        checkIdle("reset");
        rst_n = 1'b1;

        // Single read from core 0
        syncTb();
        exp_order.push_back(0);
        applyStimulus(0, 8'h12);
        waitDrained("single", 100);
        repeat (3) syncTb();
        checkOutput("single_data_hold", req_data, 32'hA5A5_0012);
        checkOutput("single_addr_hold", addr_rom, 8'h12);

        // Contention from reset: core 0 first
        resetDut();
        syncTb();
        exp_order.push_back(0);
        exp_order.push_back(1);
        applyStimulus(0, 8'h01);
        applyStimulus(1, 8'h02);
        waitDrained("contention", 100);

        // Fairness with both cores requesting back to back
        rom_lat_min = 1;
        rom_lat_max = 3;
        syncTb();
        for (int i = 0; i < 3; i++) begin
            exp_order.push_back(0);
            exp_order.push_back(1);
            applyStimulus(0, 8'($urandom));
            applyStimulus(1, 8'($urandom));
        end
        waitDrained("fairness", 300);
        checkOutput("fairness_order_consumed", exp_order.size(), 0);

        // Reset while waiting on the ROM; the late valid must be ignored
        rom_lat_min = 4;
        rom_lat_max = 4;
        syncTb();
        applyStimulus(1, 8'h55);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ce_rom !== 1'b1 && n < 20);
        checkOutput("rst_mid_wait_ce_seen", ce_rom, 1);
        syncTb();
        rst_n = 1'b0;
        syncTb();
        rst_n = 1'b1;
        repeat (6) syncTb();
        checkIdle("rst_mid_wait");
        checkOutput("rst_mid_wait_no_resp", served, issued - 1);
        served = issued;

        // Timeout: ROM never answers
        rom_lat_min = 1;
        rom_lat_max = 1;
        rom_silent  = 1'b1;
        syncTb();
        exp_order.push_back(1);
        applyStimulus(1, 8'h33);
        waitDrained("timeout", 200);
        repeat (3) syncTb();
        checkOutput("timeout_err_sticky", err, 1);
        err_clr = 1'b1;
        syncTb();
        err_clr = 1'b0;
        checkOutput("timeout_err_cleared", err, 0);

        // Timeout while clear is held: set wins, then clears
        err_clr = 1'b1;
        applyStimulus(0, 8'h44);
        waitDrained("timeout_clr", 200);
        checkOutput("timeout_clr_err_after", err, 0);
        err_clr    = 1'b0;
        rom_silent = 1'b0;

        // Guard: core 0 lingers, core 1 asks during the stale cycle
        resetDut();
        hold_extra[0] = 1'b1;
        syncTb();
        exp_order.push_back(0);
        exp_order.push_back(1);
        applyStimulus(0, 8'h61);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_valid[0] !== 1'b1 && n < 50);
        checkOutput("guard_first_valid_seen", req_valid[0], 1);
        #1;
        applyStimulus(1, 8'h62);
        waitDrained("guard_pair", 100);

        // Guard: core 0 lingers alone and must not be served twice
        syncTb();
        exp_order.push_back(0);
        applyStimulus(0, 8'h63);
        waitDrained("guard_alone", 100);
        repeat (4) syncTb();
        checkOutput("guard_alone_idle", busy, 0);
        hold_extra[0] = 1'b0;

        // Randomised traffic
        rom_lat_min = 1;
        rom_lat_max = 4;
        for (int i = 0; i < 60; i++) begin
            syncTb();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(2, 0) == 0) applyStimulus(k, 8'($urandom));
                hold_extra[k] = ($urandom_range(3, 0) == 0);
            end
        end
        waitDrained("random", 3000);
        checkOutput("served_eq_issued", served, issued);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
